// File: rtl/aes256_para16.sv
// ---------------------------------------------------------------------------
// aes256_para16
//
// Sixteen-lane parallel AES-256 round engine used by the AES-256-CTR
// keystream generator. Every cycle each lane applies the round chosen by
// `round` to its own 128-bit state with the shared round key, and the result
// is registered. An external controller walks rounds 0..14 and feeds
// output_text back to input_text, so one 15-cycle pass yields 16 ciphertext
// blocks. Key expansion and counter generation live outside this block.
//
// Ports
//   clk          single clock, all state changes on its rising edge
//   rst_n        synchronous reset, active HIGH despite the name; clears all
//                lane state and wins over any round operation
//   input_text   LANES x 128-bit states, lane i at [128*(i+1)-1 -: 128]
//   round_key    128-bit round key, shared by all lanes
//   round        0 = AddRoundKey only, 1..13 = full round,
//                14 = final round (no MixColumns), 15 = hold
//   output_text  registered round result, same lane packing as input_text
//
// Byte order inside a lane follows FIPS-197: byte k sits at [127-8k -: 8],
// and state cell s[r][c] is byte 4c+r (column-major).
// ---------------------------------------------------------------------------
module aes256_para16 #(
   parameter int LANES      = 16,
   parameter int BLOCK_SIZE = 128
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [LANES*BLOCK_SIZE-1:0]   input_text,
   input  logic [BLOCK_SIZE-1:0]         round_key,
   input  logic [3:0]                    round,
   output logic [LANES*BLOCK_SIZE-1:0]   output_text
);

   // Forward S-box, entry 0 in the most significant byte so SBOX[b] is S(b).
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   localparam int LANE_BYTES = BLOCK_SIZE / 8;

   // Multiply by x in GF(2^8) modulo 0x11B.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // SubBytes followed by ShiftRows. Row r of the result comes from column
   // (c + r) mod 4 of the substituted state, i.e. a left rotation by r.
   function automatic logic [127:0] sub_shift(input logic [127:0] s);
      logic [7:0]   sb [16];
      logic [127:0] res;
      res = '0;
      for (int k = 0; k < 16; k++) begin
         sb[k] = SBOX[s[127-8*k -: 8]];
      end
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            res[127-8*(4*c+r) -: 8] = sb[4*((c+r)%4)+r];
         end
      end
      return res;
   endfunction

   // MixColumns on each of the four columns independently.
   // 3*a is computed as xtime(a) ^ a.
   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] res;
      logic [7:0]   a0, a1, a2, a3;
      res = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-8*(4*c+0) -: 8];
         a1 = s[127-8*(4*c+1) -: 8];
         a2 = s[127-8*(4*c+2) -: 8];
         a3 = s[127-8*(4*c+3) -: 8];
         res[127-8*(4*c+0) -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         res[127-8*(4*c+1) -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         res[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         res[127-8*(4*c+3) -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return res;
   endfunction

   logic [LANES*BLOCK_SIZE-1:0] text_reg;
   logic [LANES*BLOCK_SIZE-1:0] text_next;

   // One independent round datapath per lane; only round/round_key are shared.
   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         logic [BLOCK_SIZE-1:0] lane_in;
         logic [BLOCK_SIZE-1:0] lane_ss;
         logic [BLOCK_SIZE-1:0] lane_mc;
         logic [BLOCK_SIZE-1:0] lane_next;

         assign lane_in = input_text[BLOCK_SIZE*(gi+1)-1 -: BLOCK_SIZE];
         assign lane_ss = sub_shift(lane_in);
         assign lane_mc = mix_columns(lane_ss);

         always_comb begin
            lane_next = lane_mc ^ round_key;
            case (round)
               4'd0:    lane_next = lane_in ^ round_key;
               4'd14:   lane_next = lane_ss ^ round_key;
               default: lane_next = lane_mc ^ round_key;
            endcase
         end

         assign text_next[BLOCK_SIZE*(gi+1)-1 -: BLOCK_SIZE] = lane_next;
      end
   endgenerate

   // Round 15 is a defined hold: the register simply keeps its value.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         text_reg <= '0;
      end else if (round != 4'd15) begin
         text_reg <= text_next;
      end
   end

   assign output_text = text_reg;

   // LANE_BYTES ties the per-lane byte count to the block width used above.
   logic unused_ok;
   assign unused_ok = (LANE_BYTES == 16);

endmodule

// File: tb/tb_aes256_para16.sv
// ---------------------------------------------------------------------------
// tb_aes256_para16
//
// Directed bench for the 16-lane AES-256 round engine. Inputs are driven and
// outputs sampled on the falling edge, so each cycle() call is one registered
// round operation. Full passes use a bench-side key schedule and feed the DUT
// output back as the next input, as the real controller does.
// ---------------------------------------------------------------------------
module tb_aes256_para16;

   localparam int LANES = 16;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [LANES*128-1:0] input_text;
   logic [127:0]        round_key;
   logic [3:0]          round;
   logic [LANES*128-1:0] output_text;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   aes256_para16 #(.LANES(LANES), .BLOCK_SIZE(128)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .input_text  (input_text),
      .round_key   (round_key),
      .round       (round),
      .output_text (output_text)
   );

   localparam logic [0:255][7:0] SBOX_T = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   logic [31:0]  w  [60];
   logic [127:0] rk [15];

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [127:0] lane_of(input logic [LANES*128-1:0] v, input int i);
      return v[128*(i+1)-1 -: 128];
   endfunction

   // AES-256 key schedule: 60 words, round key r = w[4r..4r+3].
   task automatic expand_key(input logic [255:0] key);
      logic [31:0] t;
      logic [7:0]  rcon;
      rcon = 8'h01;
      for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
      for (int i = 8; i < 60; i++) begin
         t = w[i-1];
         if (i % 8 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {SBOX_T[t[31:24]], SBOX_T[t[23:16]], SBOX_T[t[15:8]], SBOX_T[t[7:0]]}
                ^ {rcon, 24'h0};
            rcon = xt(rcon);
         end else if (i % 8 == 4) begin
            t = {SBOX_T[t[31:24]], SBOX_T[t[23:16]], SBOX_T[t[15:8]], SBOX_T[t[7:0]]};
         end
         w[i] = w[i-8] ^ t;
      end
      for (int r = 0; r < 15; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // Reference encryption on a 4x4 state matrix st[row][col].
   function automatic logic [127:0] ref_encrypt(input logic [127:0] pt);
      logic [7:0]   st  [4][4];
      logic [7:0]   row [4];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] x;
      x = pt ^ rk[0];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) st[r][c] = x[127-8*(4*c+r) -: 8];
      for (int rnd = 1; rnd < 15; rnd++) begin
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) st[r][c] = SBOX_T[st[r][c]];
         for (int r = 1; r < 4; r++) begin
            for (int c = 0; c < 4; c++) row[c] = st[r][(c+r)%4];
            for (int c = 0; c < 4; c++) st[r][c] = row[c];
         end
         if (rnd < 14) begin
            for (int c = 0; c < 4; c++) begin
               a0 = st[0][c]; a1 = st[1][c]; a2 = st[2][c]; a3 = st[3][c];
               st[0][c] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
               st[1][c] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
               st[2][c] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
               st[3][c] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
         end
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) st[r][c] = st[r][c] ^ rk[rnd][127-8*(4*c+r) -: 8];
      end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) x[127-8*(4*c+r) -: 8] = st[r][c];
      return x;
   endfunction

   // Drive one operation and wait until its result is registered.
   task automatic cycle(input logic [LANES*128-1:0] din, input logic [127:0] k,
                        input logic [3:0] r);
      input_text = din;
      round_key  = k;
      round      = r;
      @(negedge clk);
   endtask

   task automatic run_pass(input logic [LANES*128-1:0] pt);
      cycle(pt, rk[0], 4'd0);
      for (int r = 1; r < 15; r++) cycle(output_text, rk[r], 4'(r));
   endtask

   task automatic test_reset;
      rst_n = 1'b1;
      cycle({16{128'hdeadbeef_01234567_89abcdef_55aa55aa}}, 128'hffff, 4'd3);
      checks++;
      if (output_text !== '0)
         $display("FAIL reset_clear: got %h want 0", output_text[127:0]);
      else passed++;
      rst_n = 1'b0;
      $display("test_reset: out lane0 = %h", lane_of(output_text, 0));
   endtask

   task automatic test_whitening;
      logic [LANES*128-1:0] din, exp;
      logic [127:0] k;
      k   = 128'h000102030405060708090a0b0c0d0e0f;
      din = '0;
      din[127:0] = 128'h00112233445566778899aabbccddeeff;
      exp = {{15{k}}, 128'h00102030405060708090a0b0c0d0e0f0};
      cycle(din, k, 4'd0);
      checks++;
      if (output_text !== exp)
         $display("FAIL whitening: got lane0 %h lane1 %h want %h %h",
                  lane_of(output_text, 0), lane_of(output_text, 1), exp[127:0], k);
      else passed++;
      $display("test_whitening: out lane0 = %h", lane_of(output_text, 0));
   endtask

   task automatic test_round1;
      logic [LANES*128-1:0] din, exp;
      logic [127:0] k;
      k   = 128'h101112131415161718191a1b1c1d1e1f;
      din = '0;
      din[127:0] = 128'h00102030405060708090a0b0c0d0e0f0;
      // Zero lanes: SubBytes gives 63 everywhere, MixColumns keeps a constant column.
      exp = {{15{128'h73727170777675747b7a79787f7e7d7c}},
             128'h4f63760643e0aa85efa7213201a4e705};
      cycle(din, k, 4'd1);
      checks++;
      if (output_text !== exp)
         $display("FAIL round1: got lane0 %h lane1 %h want %h %h",
                  lane_of(output_text, 0), lane_of(output_text, 1), exp[127:0], exp[255:128]);
      else passed++;
      $display("test_round1: out lane0 = %h", lane_of(output_text, 0));
   endtask

   task automatic test_full_pass;
      logic [LANES*128-1:0] din;
      logic [127:0] ref1;
      expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
      din = '0;
      din[127:0] = 128'h00112233445566778899aabbccddeeff;
      run_pass(din);
      checks++;
      if (lane_of(output_text, 0) !== 128'h8ea2b7ca516745bfeafc49904b496089)
         $display("FAIL full_pass_lane0: got %h want 8ea2b7ca516745bfeafc49904b496089",
                  lane_of(output_text, 0));
      else passed++;
      ref1 = ref_encrypt(128'h0);
      checks++;
      if (lane_of(output_text, 1) !== ref1)
         $display("FAIL full_pass_lane1: got %h want %h", lane_of(output_text, 1), ref1);
      else passed++;
      $display("test_full_pass: ciphertext lane0 = %h", lane_of(output_text, 0));
   endtask

   task automatic test_reset_mid_pass;
      logic [LANES*128-1:0] din;
      din = {16{128'h00112233445566778899aabbccddeeff}};
      cycle(din, rk[0], 4'd0);
      for (int r = 1; r < 7; r++) cycle(output_text, rk[r], 4'(r));
      checks++;
      if (output_text === '0)
         $display("FAIL mid_pass_state: got all-zero state before reset, want nonzero");
      else passed++;
      rst_n = 1'b1;
      cycle(output_text, rk[7], 4'd7);
      rst_n = 1'b0;
      checks++;
      if (output_text !== '0)
         $display("FAIL mid_pass_reset: got lane0 %h want 0", lane_of(output_text, 0));
      else passed++;
      $display("test_reset_mid_pass: out lane0 = %h", lane_of(output_text, 0));
   endtask

   task automatic test_zero_hold;
      logic [LANES*128-1:0] all63;
      all63 = {256{8'h63}};
      cycle('0, 128'h0, 4'd5);
      checks++;
      if (output_text !== all63)
         $display("FAIL zero_round5: got lane0 %h want all 63", lane_of(output_text, 0));
      else passed++;
      cycle('0, 128'h0, 4'd14);
      checks++;
      if (output_text !== all63)
         $display("FAIL zero_round14: got lane0 %h want all 63", lane_of(output_text, 0));
      else passed++;
      for (int i = 0; i < 3; i++) begin
         cycle({16{128'h0123456789abcdef0011223344556677 + 128'(i)}},
               128'hcafef00d + 128'(i), 4'd15);
         checks++;
         if (output_text !== all63)
            $display("FAIL hold_%0d: got lane0 %h want all 63", i, lane_of(output_text, 0));
         else passed++;
      end
      $display("test_zero_hold: out lane15 = %h", lane_of(output_text, 15));
   endtask

   task automatic test_lane_isolation;
      logic [LANES*128-1:0] din;
      logic [127:0] exp [16];
      logic [127:0] pt;
      expand_key(256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4);
      din = '0;
      din[127:0]   = 128'h6bc1bee22e409f96e93d7e117393172a;
      din[255:128] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
      din[383:256] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
      din[511:384] = 128'hf69f2445df4f9b17ad2b417be66c3710;
      exp[0] = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;
      exp[1] = 128'h591ccb10d410ed26dc5ba74a31362870;
      exp[2] = 128'hb6ed21b99ca6f4f9f153e7b1beafed1d;
      exp[3] = 128'h23304b7a39f9f3ff067d8d8f9e24ecc7;
      for (int i = 4; i < 16; i++) begin
         pt = {4{32'(i) * 32'h01010101}} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
         din[128*(i+1)-1 -: 128] = pt;
         exp[i] = ref_encrypt(pt);
      end
      run_pass(din);
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (lane_of(output_text, i) !== exp[i])
            $display("FAIL lane_%0d: got %h want %h", i, lane_of(output_text, i), exp[i]);
         else passed++;
      end
      $display("test_lane_isolation: lane15 [2047:1920] = %h", output_text[2047:1920]);
   endtask

   initial begin
      rst_n      = 1'b0;
      input_text = '0;
      round_key  = '0;
      round      = 4'd15;
      @(negedge clk);
      test_reset();
      test_whitening();
      test_round1();
      test_full_pass();
      test_reset_mid_pass();
      test_zero_hold();
      test_lane_isolation();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
